pipe_stage_buf: RTL

//  Generic inter-stage pipeline buffer: valid/ready handshake replaces raw stall/flush enables.

---
 rtl/pipe_stage_buf.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready inter-stage pipeline buffer with separate
// control/data payloads, optional skid entry and a saturating stall counter.
// Control reads back as CTRL_NOP and data as zero whenever the buffer is empty.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int unsigned       SKID     = 1,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i,
  output logic [1:0]        occ_o,
  input  logic              clr_cnt_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              head_vld_q, head_vld_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              skid_vld_q, skid_vld_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push, pop;

  assign push = valid_i && ready_o;
  assign pop  = head_vld_q && ready_i;

  // Next-state for head/skid entries; flush overrides any push/pop.
  always_comb begin
    head_vld_d  = head_vld_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    skid_vld_d  = skid_vld_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      head_vld_d  = 1'b0;
      head_ctrl_d = CTRL_NOP;
      head_data_d = '0;
      skid_vld_d  = 1'b0;
      skid_ctrl_d = CTRL_NOP;
      skid_data_d = '0;
    end else if (!head_vld_q) begin
      if (push) begin
        head_vld_d  = 1'b1;
        head_ctrl_d = ctrl_i;
        head_data_d = data_i;
      end
    end else if (!skid_vld_q) begin
      if (pop && push) begin
        head_ctrl_d = ctrl_i;
        head_data_d = data_i;
      end else if (pop) begin
        head_vld_d  = 1'b0;
        head_ctrl_d = CTRL_NOP;
        head_data_d = '0;
      end else if (push && (SKID != 0)) begin
        skid_vld_d  = 1'b1;
        skid_ctrl_d = ctrl_i;
        skid_data_d = data_i;
      end
    end else begin
      // Both entries full: ready_o is low, so only a pop can happen.
      if (pop) begin
        head_ctrl_d = skid_ctrl_q;
        head_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
        skid_ctrl_d = CTRL_NOP;
        skid_data_d = '0;
      end
    end
  end

  // Saturating stall counter; clear wins over increment, flush leaves it alone.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (head_vld_q && !ready_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Entry storage and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_vld_q  <= 1'b0;
      head_ctrl_q <= CTRL_NOP;
      head_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_ctrl_q <= CTRL_NOP;
      skid_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      head_vld_q  <= head_vld_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid_rdy
      logic rdy_q;
      // Registered ready: low exactly when both entries will be occupied.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= !(head_vld_d && skid_vld_d);
        end
      end
      assign ready_o = rdy_q;
    end else begin : g_comb_rdy
      assign ready_o = !head_vld_q || ready_i;
    end
  endgenerate

  assign valid_o     = head_vld_q;
  assign ctrl_o      = head_vld_q ? head_ctrl_q : CTRL_NOP;
  assign data_o      = head_vld_q ? head_data_q : '0;
  assign occ_o       = {1'b0, head_vld_q} + {1'b0, skid_vld_q};
  assign stall_cnt_o = cnt_q;

endmodule
